// File: rtl/tlc_pkg.sv
// Shared types and lamp encodings for the N-approach traffic-light controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    YELLOW = 2'd1,
    CLEAR  = 2'd2,
    WALK   = 2'd3
  } tlc_state_e;

  // Lamp triplets are ordered {G,Y,R}.
  localparam logic [2:0] LAMP_G = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b001;

endpackage

// File: rtl/tlc_timer.sv
// Loadable down-counter paced by tick; expired flags a tick seen while at zero.
module tlc_timer #(
  parameter int            TW      = 8,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          tick_i,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  output logic          expired_o
);

  logic [TW-1:0] count_q, count_d;

  // Gating the decrement on a non-zero count keeps the arithmetic from wrapping.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = tick_i && (count_q == '0);

endmodule

// File: rtl/traffic_light_ctrl_n.sv
// N-approach traffic-light controller with sensor green extension and an all-red walk phase.
// Optional all-red clearance after every yellow and walk: define TLC_ALL_RED_CLEARANCE_EN.
module traffic_light_ctrl_n
  import tlc_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int TW       = 8,
  parameter int T_GREEN  = 4,
  parameter int T_EXT    = 2,
  parameter int MAX_EXT  = 1,
  parameter int T_YELLOW = 2,
  parameter int T_WALK   = 3,
  parameter int T_CLEAR  = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       walk_btn,
  input  logic [N_DIR-1:0]           sensor,
  output logic [3*N_DIR-1:0]         lights,
  output logic                       walk_lamp,
  output logic                       walk_pending,
  output logic [$clog2(N_DIR)-1:0]   phase,
  output tlc_state_e                 dbg_state
);

  localparam int PW = $clog2(N_DIR);
  localparam int EW = (MAX_EXT < 1) ? 1 : $clog2(MAX_EXT + 1);

  tlc_state_e        state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d, next_ph;
  logic [EW-1:0]     ext_q, ext_d;
  logic              walk_pending_q, walk_pending_d;
  logic [3*N_DIR-1:0] lights_q;
  logic              walk_lamp_q;
  logic              expired, load, extend, adv, last_ph;
  logic [TW-1:0]     load_val;
`ifdef TLC_ALL_RED_CLEARANCE_EN
  logic              from_walk_q, from_walk_d;
`endif

  function automatic logic [3*N_DIR-1:0] lamps(tlc_state_e s, logic [PW-1:0] ph);
    logic [3*N_DIR-1:0] l;
    for (int p = 0; p < N_DIR; p++) begin
      l[3*p +: 3] = LAMP_R;
      if (PW'(p) == ph) begin
        if (s == GREEN) l[3*p +: 3] = LAMP_G;
        else if (s == YELLOW) l[3*p +: 3] = LAMP_Y;
      end
    end
    return l;
  endfunction

  tlc_timer #(
    .TW      (TW),
    .RST_VAL (TW'(T_GREEN - 1))
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .tick_i     (tick),
    .load_i     (load),
    .load_val_i (load_val),
    .expired_o  (expired)
  );

  assign last_ph = (phase_q == PW'(N_DIR - 1));
  assign next_ph = last_ph ? '0 : phase_q + PW'(1);

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    ext_d          = ext_q;
    walk_pending_d = (state_q == WALK) ? walk_pending_q : (walk_pending_q | walk_btn);
    load           = 1'b0;
    extend         = 1'b0;
    adv            = 1'b0;
`ifdef TLC_ALL_RED_CLEARANCE_EN
    from_walk_d    = from_walk_q;
`endif
    if (expired) begin
      load = 1'b1;
      unique case (state_q)
        GREEN: begin
          if (sensor[phase_q] && (32'(ext_q) < MAX_EXT)) begin
            extend = 1'b1;
            ext_d  = ext_q + EW'(1);
          end else begin
            state_d = YELLOW;
          end
        end
        YELLOW: begin
`ifdef TLC_ALL_RED_CLEARANCE_EN
          state_d     = CLEAR;
          from_walk_d = 1'b0;
`else
          adv = 1'b1;
`endif
        end
        CLEAR: begin
`ifdef TLC_ALL_RED_CLEARANCE_EN
          if (from_walk_q) begin
            state_d = GREEN;
            ext_d   = '0;
          end else begin
            adv = 1'b1;
          end
`else
          state_d = GREEN;
`endif
        end
        WALK: begin
          phase_d = '0;
`ifdef TLC_ALL_RED_CLEARANCE_EN
          state_d     = CLEAR;
          from_walk_d = 1'b1;
`else
          state_d = GREEN;
          ext_d   = '0;
`endif
        end
      endcase
    end

    // Leaving yellow (or its clearance): serve the walk request after the last approach.
    if (adv) begin
      if (last_ph && walk_pending_q) begin
        state_d        = WALK;
        walk_pending_d = 1'b0;
      end else begin
        state_d = GREEN;
        phase_d = next_ph;
        ext_d   = '0;
      end
    end

    case (state_d)
      GREEN:   load_val = TW'(T_GREEN - 1);
      YELLOW:  load_val = TW'(T_YELLOW - 1);
      CLEAR:   load_val = TW'(T_CLEAR - 1);
      WALK:    load_val = TW'(T_WALK - 1);
      default: load_val = TW'(T_GREEN - 1);
    endcase
    if (extend) load_val = TW'(T_EXT - 1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= GREEN;
      phase_q        <= '0;
      ext_q          <= '0;
      walk_pending_q <= 1'b0;
      lights_q       <= lamps(GREEN, PW'(0));
      walk_lamp_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      ext_q          <= ext_d;
      walk_pending_q <= walk_pending_d;
      lights_q       <= lamps(state_d, phase_d);
      walk_lamp_q    <= (state_d == WALK);
    end
  end

`ifdef TLC_ALL_RED_CLEARANCE_EN
  always_ff @(posedge clock) begin
    if (reset) from_walk_q <= 1'b0;
    else       from_walk_q <= from_walk_d;
  end
`endif

  assign lights       = lights_q;
  assign walk_lamp    = walk_lamp_q;
  assign walk_pending = walk_pending_q;
  assign phase        = phase_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Bench for traffic_light_ctrl_n: per-cycle expected outputs from a remaining-ticks model, checked by a monitor.
module tb_traffic_light_ctrl_n;
  import tlc_pkg::*;

  localparam int N_DIR = 2, TW = 8, T_GREEN = 4, T_EXT = 2, MAX_EXT = 1;
  localparam int T_YELLOW = 2, T_WALK = 3, T_CLEAR = 1;
  localparam int PW = $clog2(N_DIR);
  localparam int W  = 3*N_DIR + 2 + PW;
  localparam int MG = 0, MY = 1, MW = 2, MC = 3;

  logic clock = 1'b0;
  logic reset, tick, walk_btn;
  logic [N_DIR-1:0]   sensor;
  logic [3*N_DIR-1:0] lights;
  logic               walk_lamp, walk_pending;
  logic [PW-1:0]      phase;
  tlc_state_e         dbg_state;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // model state: mode, approach, ticks left in current interval, extensions used
  int m_mode, m_ph, m_rem, m_ext, m_pend, m_from_walk;

  traffic_light_ctrl_n #(
    .N_DIR(N_DIR), .TW(TW), .T_GREEN(T_GREEN), .T_EXT(T_EXT), .MAX_EXT(MAX_EXT),
    .T_YELLOW(T_YELLOW), .T_WALK(T_WALK), .T_CLEAR(T_CLEAR)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick), .walk_btn(walk_btn), .sensor(sensor),
    .lights(lights), .walk_lamp(walk_lamp), .walk_pending(walk_pending),
    .phase(phase), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    logic [3*N_DIR-1:0] l;
    for (int p = 0; p < N_DIR; p++) begin
      l[3*p +: 3] = 3'b001;
      if (p == m_ph && m_mode == MG) l[3*p +: 3] = 3'b100;
      if (p == m_ph && m_mode == MY) l[3*p +: 3] = 3'b010;
    end
    return {l, (m_mode == MW), m_pend[0], PW'(m_ph)};
  endfunction

  function automatic void model_step(input logic r, input logic tk, input logic wb,
                                     input logic [N_DIR-1:0] sn);
    int new_pend;
    int after_yellow;
    after_yellow = 0;
    if (r) begin
      m_mode = MG; m_ph = 0; m_rem = T_GREEN; m_ext = 0; m_pend = 0; m_from_walk = 0;
      return;
    end
    new_pend = (m_mode == MW) ? m_pend : (m_pend | int'(wb));
    if (tk) begin
      m_rem--;
      if (m_rem == 0) begin
        case (m_mode)
          MG: begin
            if (sn[m_ph] && m_ext < MAX_EXT) begin m_ext++; m_rem = T_EXT; end
            else begin m_mode = MY; m_rem = T_YELLOW; end
          end
          MY: begin
`ifdef TLC_ALL_RED_CLEARANCE_EN
            m_mode = MC; m_rem = T_CLEAR; m_from_walk = 0;
`else
            after_yellow = 1;
`endif
          end
          MC: begin
            if (m_from_walk != 0) begin m_mode = MG; m_ph = 0; m_ext = 0; m_rem = T_GREEN; end
            else after_yellow = 1;
          end
          default: begin
            m_ph = 0;
`ifdef TLC_ALL_RED_CLEARANCE_EN
            m_mode = MC; m_rem = T_CLEAR; m_from_walk = 1;
`else
            m_mode = MG; m_ext = 0; m_rem = T_GREEN;
`endif
          end
        endcase
      end
    end
    if (after_yellow != 0) begin
      if (m_ph == N_DIR - 1 && m_pend != 0) begin
        m_mode = MW; m_rem = T_WALK; new_pend = 0;
      end else begin
        m_mode = MG; m_ph = (m_ph + 1) % N_DIR; m_ext = 0; m_rem = T_GREEN;
      end
    end
    m_pend = new_pend;
  endfunction

  // Apply inputs for the next edge, then record what that edge must produce.
  task automatic drive_cycle(input logic r, input logic tk, input logic wb,
                             input logic [N_DIR-1:0] sn);
    reset = r; tick = tk; walk_btn = wb; sensor = sn;
    @(posedge clock);
    #1;
    model_step(r, tk, wb, sn);
    exp_q.push_back(model_out());
  endtask

  task automatic run(input int n, input logic tk, input logic [N_DIR-1:0] sn);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, tk, 1'b0, sn);
  endtask

  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("lights",       32'(lights),       32'(e[W-1 -: 3*N_DIR]));
        check("walk_lamp",    32'(walk_lamp),    32'(e[PW+1]));
        check("walk_pending", 32'(walk_pending), 32'(e[PW]));
        check("phase",        32'(phase),        32'(e[PW-1:0]));
      end
    end
  end

  initial begin : stimulus
    int guard;
    reset = 1'b1; tick = 1'b1; walk_btn = 1'b0; sensor = '0;

    drive_cycle(1'b1, 1'b1, 1'b0, '0);
    drive_cycle(1'b1, 1'b1, 1'b0, '0);
    run(24, 1'b1, '0);

    drive_cycle(1'b1, 1'b1, 1'b0, '0);
    run(20, 1'b1, 2'b01);

    drive_cycle(1'b1, 1'b1, 1'b0, '0);
    drive_cycle(1'b0, 1'b1, 1'b1, '0);
    run(24, 1'b1, '0);

    drive_cycle(1'b1, 1'b1, 1'b0, '0);
    run(2, 1'b1, '0);
    run(10, 1'b0, '0);
    drive_cycle(1'b0, 1'b0, 1'b1, '0);
    run(12, 1'b1, '0);

    drive_cycle(1'b1, 1'b1, 1'b0, '0);
    drive_cycle(1'b0, 1'b1, 1'b1, '0);
    guard = 0;
    while (m_mode != MW && guard < 60) begin
      run(1, 1'b1, '0);
      guard++;
    end
    if (m_mode != MW) begin
      n_checks++; n_fail++;
      $display("FAIL walk_reach: model never entered walk within %0d cycles", guard);
    end
    run(1, 1'b1, '0);
    drive_cycle(1'b1, 1'b1, 1'b1, '0);
    run(10, 1'b1, '0);

    for (int i = 0; i < 3000; i++) begin
      drive_cycle($urandom_range(0, 399) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 24) == 0,
                  N_DIR'($urandom_range(0, (1 << N_DIR) - 1)));
    end

    @(negedge clock);
    @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
